// File: rtl/mesh_term_tx_pkg.sv
// Packet layout shared by the mesh terminal transmit path (package mesh_pkg).
package mesh_pkg;

    localparam int         PKG_SZ_DEFAULT = 40;
    localparam int         HDR_W          = 17;
    localparam logic [7:0] BDCST_DEFAULT  = 8'hFF;

    // Bit positions at the default width; other widths shift by (pckg_sz - PKG_SZ_DEFAULT).
    localparam int NXT_JMP_MSB = PKG_SZ_DEFAULT - 1;
    localparam int ROW_MSB     = PKG_SZ_DEFAULT - 9;
    localparam int COL_MSB     = PKG_SZ_DEFAULT - 13;
    localparam int MODE_BIT    = PKG_SZ_DEFAULT - 17;
    localparam int PAYLOAD_MSB = PKG_SZ_DEFAULT - 18;

    typedef struct packed {
        logic [7:0] nxt_jmp;
        logic [3:0] row;
        logic [3:0] col;
        logic       mode;
    } pkt_hdr_t;

    // Header sits above the payload; broadcast replaces the whole row/col byte.
    function automatic pkt_hdr_t pkt_pack(
        input logic [3:0] row,
        input logic [3:0] col,
        input logic       mode,
        input logic       bcast,
        input logic [7:0] bdcst
    );
        pkt_hdr_t h;
        h.nxt_jmp = 8'h00;
        h.row     = bcast ? bdcst[7:4] : row;
        h.col     = bcast ? bdcst[3:0] : col;
        h.mode    = mode;
        return h;
    endfunction

endpackage

// File: rtl/mesh_term_tx_fifo.sv
// mesh_sync_fifo: synchronous FIFO with arbitrary depth, registered head and
// simultaneous push/pop allowed when full.
module mesh_sync_fifo #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             push_ok
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push is about to use.
    assign push_ok = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push_ok && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !push_ok)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mesh_term_tx.sv
// Terminal-side injection endpoint: packs host fields and queues them for the router.
// Optional MESH_TERM_TX_STATS_EN adds saturating push/pop/drop counters.
module mesh_term_tx
    import mesh_pkg::*;
#(
    parameter int         pckg_sz    = 40,
    parameter int         fifo_depth = 4,
    parameter logic [7:0] bdcst      = BDCST_DEFAULT,
    parameter int         TERM_ID    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [3:0]            dst_row,
    input  logic [3:0]            dst_col,
    input  logic                  mode,
    input  logic                  bcast,
    input  logic [pckg_sz-18:0]   payload,
    output logic                  wr_ack,
    output logic                  full,
    output logic [pckg_sz-1:0]    data_out_i_in,
    output logic                  pndng_i_in,
    input  logic                  popin,
    output logic                  overflow,
    output logic                  underflow_err
`ifdef MESH_TERM_TX_STATS_EN
    ,
    output logic [15:0]           tx_cnt,
    output logic [15:0]           pop_cnt,
    output logic [15:0]           drop_cnt
`endif
);

    if (pckg_sz < 24 || fifo_depth < 2 || TERM_ID < 0) begin : g_bad_cfg
        $error("mesh_term_tx: unsupported parameter combination");
    end

    pkt_hdr_t           hdr;
    logic [pckg_sz-1:0] pkt;
    logic               fifo_empty;

    assign hdr = pkt_pack(dst_row, dst_col, mode, bcast, bdcst);
    assign pkt = {hdr, payload};

    mesh_sync_fifo #(
        .WIDTH (pckg_sz),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push    (wr_en),
        .pop     (popin),
        .din     (pkt),
        .dout    (data_out_i_in),
        .full    (full),
        .empty   (fifo_empty),
        .push_ok (wr_ack)
    );

    assign pndng_i_in = !fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow      <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (wr_en && !wr_ack)      overflow      <= 1'b1;
            if (popin && !pndng_i_in)  underflow_err <= 1'b1;
        end
    end

`ifdef MESH_TERM_TX_STATS_EN
    logic pop_ok;
    logic drop;

    assign pop_ok = popin && pndng_i_in;
    assign drop   = wr_en && !wr_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_cnt   <= '0;
            pop_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (wr_ack && tx_cnt   != '1) tx_cnt   <= tx_cnt   + 1'b1;
            if (pop_ok && pop_cnt  != '1) pop_cnt  <= pop_cnt  + 1'b1;
            if (drop   && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && drop)
            $display("mesh_term_tx[%0d]: push dropped, queue full", TERM_ID);
    end
`endif
`endif

endmodule

// File: tb/tb_mesh_term_tx.sv
// Bench for mesh_term_tx: depth-4 and depth-3 instances share stimulus and are
// checked each cycle against per-instance queue models.
module tb_mesh_term_tx;

    localparam int PW = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  dst_row = '0;
    logic [3:0]  dst_col = '0;
    logic        mode = 1'b0;
    logic        bcast = 1'b0;
    logic [22:0] payload = '0;
    logic        popin = 1'b0;

    logic          wr_ack  [2];
    logic          full    [2];
    logic [PW-1:0] data    [2];
    logic          pndng   [2];
    logic          ovf_o   [2];
    logic          unf_o   [2];

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] q [2][$];
    bit            ovf [2];
    bit            unf [2];
    int            dep [2] = '{4, 3};

    always #5 clk = ~clk;

    mesh_term_tx #(
        .pckg_sz    (PW),
        .fifo_depth (4),
        .bdcst      (8'hFF),
        .TERM_ID    (0)
    ) u_dut4 (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .dst_row       (dst_row),
        .dst_col       (dst_col),
        .mode          (mode),
        .bcast         (bcast),
        .payload       (payload),
        .wr_ack        (wr_ack[0]),
        .full          (full[0]),
        .data_out_i_in (data[0]),
        .pndng_i_in    (pndng[0]),
        .popin         (popin),
        .overflow      (ovf_o[0]),
        .underflow_err (unf_o[0])
    );

    mesh_term_tx #(
        .pckg_sz    (PW),
        .fifo_depth (3),
        .bdcst      (8'hFF),
        .TERM_ID    (1)
    ) u_dut3 (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .dst_row       (dst_row),
        .dst_col       (dst_col),
        .mode          (mode),
        .bcast         (bcast),
        .payload       (payload),
        .wr_ack        (wr_ack[1]),
        .full          (full[1]),
        .data_out_i_in (data[1]),
        .pndng_i_in    (pndng[1]),
        .popin         (popin),
        .overflow      (ovf_o[1]),
        .underflow_err (unf_o[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] pack(input logic [3:0] r, input logic [3:0] c,
                                           input logic m, input logic b, input logic [22:0] p);
        logic [7:0] dst;
        dst = b ? 8'hFF : {r, c};
        return {8'h00, dst, m, p};
    endfunction

    task automatic model_step(input int k);
        int sz;
        bit ack;
        sz  = q[k].size();
        ack = wr_en && (sz < dep[k] || popin);
        if (popin && sz == 0) unf[k] = 1'b1;
        if (wr_en && !ack)    ovf[k] = 1'b1;
        if (popin && sz != 0) void'(q[k].pop_front());
        if (ack) q[k].push_back(pack(dst_row, dst_col, mode, bcast, payload));
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                q[k].delete();
                ovf[k] = 1'b0;
                unf[k] = 1'b0;
            end else begin
                model_step(k);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int sz;
            logic [PW-1:0] exp_data;
            bit exp_ack;
            sz       = q[k].size();
            exp_data = (sz != 0) ? q[k][0] : '0;
            exp_ack  = wr_en && (sz < dep[k] || popin);
            chk($sformatf("d%0d pndng", dep[k]), 64'(pndng[k]), 64'(sz != 0));
            chk($sformatf("d%0d full", dep[k]),  64'(full[k]),  64'(sz == dep[k]));
            chk($sformatf("d%0d data", dep[k]),  64'(data[k]),  64'(exp_data));
            chk($sformatf("d%0d wr_ack", dep[k]), 64'(wr_ack[k]), 64'(exp_ack));
            chk($sformatf("d%0d overflow", dep[k]), 64'(ovf_o[k]), 64'(ovf[k]));
            chk($sformatf("d%0d underflow", dep[k]), 64'(unf_o[k]), 64'(unf[k]));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_push(input logic [3:0] r, input logic [3:0] c, input logic m,
                            input logic b, input logic [22:0] p);
        wr_en   = 1'b1;
        dst_row = r;
        dst_col = c;
        mode    = m;
        bcast   = b;
        payload = p;
    endtask

    initial begin
        logic [PW-1:0] d;
        repeat (2) step();
        reset = 1'b0;
        step();
        chk("reset pndng", 64'(pndng[0]), 64'd0);
        chk("reset full", 64'(full[0]), 64'd0);
        chk("reset data", 64'(data[0]), 64'd0);
        chk("reset overflow", 64'(ovf_o[0]), 64'd0);
        chk("reset underflow", 64'(unf_o[0]), 64'd0);

        popin = 1'b1; step(); popin = 1'b0;
        chk("empty pop underflow", 64'(unf_o[0]), 64'd1);
        chk("empty pop pndng", 64'(pndng[0]), 64'd0);

        set_push(4'd2, 4'd3, 1'b1, 1'b0, 23'h1234); step(); wr_en = 1'b0;
        chk("single pndng", 64'(pndng[0]), 64'd1);
        chk("single data", 64'(data[0]), 64'h00_2_3_8_01234);
        popin = 1'b1; step(); popin = 1'b0;
        chk("single popped", 64'(pndng[0]), 64'd0);

        for (int i = 1; i <= 5; i++) begin
            set_push(4'd0, 4'd0, 1'b0, 1'b0, 23'(i));
            if (i == 5) begin
                #1;
                chk("5th push wr_ack", 64'(wr_ack[0]), 64'd0);
                chk("5th push full", 64'(full[0]), 64'd1);
            end
            step();
        end
        wr_en = 1'b0;
        chk("overflow sticky", 64'(ovf_o[0]), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain order %0d", i), 64'(data[0]), 64'(i));
            popin = 1'b1; step();
        end
        popin = 1'b0;
        chk("drained", 64'(pndng[0]), 64'd0);

        for (int i = 0; i < 4; i++) begin
            set_push(4'd1, 4'd2, 1'b0, 1'b0, 23'(32'h100 + i)); step();
        end
        for (int i = 0; i < 10; i++) begin
            set_push(4'd3, 4'd4, i[0], 1'b0, 23'(32'h200 + i));
            popin = 1'b1;
            #1;
            chk("full push+pop ack d4", 64'(wr_ack[0]), 64'd1);
            chk("full push+pop ack d3", 64'(wr_ack[1]), 64'd1);
            step();
            chk("full stays d4", 64'(full[0]), 64'd1);
            chk("full stays d3", 64'(full[1]), 64'd1);
        end
        wr_en = 1'b0;
        repeat (5) step();
        popin = 1'b0;

        for (int i = 0; i < 3; i++) begin
            set_push(4'd6, 4'd7, 1'b1, 1'b0, 23'(32'h300 + i)); step();
        end
        wr_en = 1'b0;
        popin = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("async rst pndng", 64'(pndng[0]), 64'd0);
        chk("async rst data", 64'(data[0]), 64'd0);
        chk("async rst full", 64'(full[0]), 64'd0);
        chk("async rst overflow", 64'(ovf_o[0]), 64'd0);
        chk("async rst underflow", 64'(unf_o[0]), 64'd0);
        popin = 1'b0;
        step();
        reset = 1'b0;
        set_push(4'd0, 4'd0, 1'b0, 1'b0, 23'h77); step(); wr_en = 1'b0;
        chk("post-reset head", 64'(data[0]), 64'h77);
        popin = 1'b1; step(); popin = 1'b0;

        set_push(4'd5, 4'd9, 1'b0, 1'b1, 23'h55); step();
        set_push(4'd5, 4'd9, 1'b0, 1'b0, 23'h66); step();
        wr_en = 1'b0;
        d = data[0];
        chk("bcast dst byte", 64'(d[31:24]), 64'hFF);
        popin = 1'b1; step(); popin = 1'b0;
        d = data[0];
        chk("unicast dst byte", 64'(d[31:24]), 64'h59);

        for (int i = 0; i < 4000; i++) begin
            int wr_pct;
            wr_pct  = ((i / 500) % 2 == 1) ? 85 : 45;
            wr_en   = ($urandom_range(0, 99) < wr_pct);
            popin   = ($urandom_range(0, 99) < 55);
            dst_row = 4'($urandom);
            dst_col = 4'($urandom);
            mode    = 1'($urandom);
            bcast   = ($urandom_range(0, 9) == 0);
            payload = 23'($urandom);
            reset   = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0;
        wr_en = 1'b0;
        popin = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mesh_term_tx.md
Name: mesh_term_tx

Overview:
- Terminal-side transmit endpoint for the ROWS x COLUMS mesh router.
- Sits on the far side of the per-terminal injection handshake: it produces data_out_i_in/pndng_i_in and consumes the router's popin.
- Assembles packets from host-side fields, buffers them in a fifo_depth-entry FIFO, and presents the head entry to the router until the router pops it.
- One instance per terminal (ROWS*2+COLUMS*2 instances in the test harness).

Parameters:
- pckg_sz, 40, packet width in bits (min 24)
- fifo_depth, 4, FIFO entries (min 2, need not be a power of 2)
- bdcst, {8{1'b1}}, 8-bit broadcast destination code
- TERM_ID, 0, this terminal's index, 0 .. ROWS*2+COLUMS*2-1 (used only by the stats feature)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  host push request
- dst_row  in  4  destination row
- dst_col  in  4  destination column
- mode  in  1  routing mode bit
- bcast  in  1  broadcast request; overrides dst_row/dst_col
- payload  in  pckg_sz-17  packet payload
- wr_ack  out  1  push accepted this cycle (combinational)
- full  out  1  FIFO full
- data_out_i_in  out  pckg_sz  head packet to router
- pndng_i_in  out  1  head packet valid
- popin  in  1  router pop strobe
- overflow  out  1  sticky: push dropped
- underflow_err  out  1  sticky: popin while empty

Interface (already decided): one clock, clk; reset is asynchronous and active-high, port reset.

Behaviour:
- Packet format:
  - [pckg_sz-1 -: 8] = 8'h00 (next-jump field; the router fills it)
  - [pckg_sz-9 -: 4] = dst_row
  - [pckg_sz-13 -: 4] = dst_col
  - [pckg_sz-17] = mode
  - [pckg_sz-18:0] = payload
  - When bcast=1, bits [pckg_sz-9 -: 8] = bdcst.
- State: wr_ptr, rd_ptr (0..fifo_depth-1, wrap to 0 after fifo_depth-1) and count (width $clog2(fifo_depth+1)).
- Outputs derived from registers only:
  - pndng_i_in = (count != 0)
  - full = (count == fifo_depth)
  - data_out_i_in = mem[rd_ptr] when pndng_i_in, else all zeros
- Push:
  - wr_ack = wr_en && (!full || popin).
  - On wr_ack, the assembled packet is written to mem[wr_ptr] at the clock edge and wr_ptr advances.
- Pop:
  - On popin && pndng_i_in, rd_ptr advances at the edge.
  - The next head is visible the following cycle.
  - The router may hold popin high on consecutive cycles; each high cycle pops one entry.
- Latency: a push into an empty FIFO at edge t gives pndng_i_in=1 and valid data after edge t (not fall-through).
- Simultaneous push and pop:
  - count unchanged, both pointers advance.
  - Legal when full: slot freed and refilled in the same cycle.
  - When empty, the pop is ignored and the push proceeds (count becomes 1). underflow_err is still set.
- Full and no pop: wr_en is dropped, wr_ack=0, overflow set (sticky). FIFO contents unchanged.
- Empty and popin: no state change except underflow_err set (sticky).
- Reset (async, any time including mid-transfer):
  - pointers, count, overflow, underflow_err <= 0
  - pndng_i_in=0, full=0, data_out_i_in=0 immediately
  - mem contents don't-care and never observable
- Sticky flags clear only on reset.

Optional Feature:
- Macro: MESH_TERM_TX_STATS_EN
- Defined:
  - Adds outputs tx_cnt[15:0] (accepted pushes), pop_cnt[15:0] (successful pops) and drop_cnt[15:0] (overflow drops).
  - All three saturate at 16'hFFFF and reset to 0.
  - Adds a TERM_ID-tagged $display on each drop (simulation only).
- Undefined: ports and counters are absent; TERM_ID is unused.

Decomposition:
- Package mesh_pkg:
  - field offset localparams (NXT_JMP_MSB, ROW_MSB, COL_MSB, MODE_BIT, PAYLOAD_MSB)
  - typedef for packet struct/function pkt_pack(row, col, mode, bcast, payload)
  - BDCST_DEFAULT constant
- One natural sub-module: mesh_sync_fifo (parametric depth/width; push/pop/full/empty/count, non-power-of-2 wrap).
- mesh_term_tx wraps mesh_sync_fifo with packet assembly, flags and stats.

Test Plan:
- Reset then idle: pndng_i_in=0, full=0, data_out_i_in=0, flags 0; popin pulse sets underflow_err=1, count stays 0.
- Push dst_row=2, dst_col=3, mode=1, payload=23'h1234, no popin: next cycle pndng_i_in=1, data_out_i_in=40'h00_2_3_8_01234 (fields as packed); popin 1 cycle: pndng_i_in=0 next cycle.
- Push 5 packets with fifo_depth=4 and no popin: wr_ack low on 5th, full=1, overflow=1; pops return packets 1..4 in order.
- Full FIFO with wr_en and popin same cycle: wr_ack=1, count stays 4, output order preserved across wrap; repeat 10 cycles with fifo_depth=3 to check non-power-of-2 wrap.
- bcast=1, dst_row=5: data_out_i_in[31:24]=8'hFF; bcast=0 restores dst fields.
- Assert reset mid-stream with 3 entries queued and popin high: outputs clear asynchronously within the cycle; after release, the first new push is the first packet seen (no stale data).
